key_mode_select: RTL and testbench

Two-button front-end that produces the 8-bit `value` consumed by the segment display stage. It synchronises and debounces two active-low push-buttons and turns each clean press into a register update:
- the low nibble holds the heartbeat mode;
- the high nibble holds the speed level.

The mode nibble is held in the range 1..MODE_MAX, so the display's zero/out-of-range warning only fires for a true fault.

---
 rtl/key_mode_select.sv | 109 ++++++++++
 tb/tb_key_mode_select.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/key_mode_select.sv
// key_mode_select
//   Two-button front-end for the segment display. Each active-low, bouncy
//   button is synchronised (2 flops) and debounced independently. A clean
//   press (stable 1->0) advances the mode nibble (1..MODE_MAX, wrapping to 1)
//   or the speed nibble (0..SPEED_MAX, wrapping to 0). Presses of both keys
//   accepted on the same cycle load the defaults (mode 1, speed 0).
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   key_mode_n   mode button, active-low, asynchronous
//   key_speed_n  speed button, active-low, asynchronous
//   value        {speed[3:0], mode[3:0]}, registered
//   mode_pulse   one-cycle strobe per accepted mode press
//   speed_pulse  one-cycle strobe per accepted speed press
module key_mode_select #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int MODE_MAX        = 3,
  parameter int SPEED_MAX       = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode_n,
  input  logic       key_speed_n,
  output logic [7:0] value,
  output logic       mode_pulse,
  output logic       speed_pulse
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]      MODE_LIM  = 4'(MODE_MAX);
  localparam logic [3:0]      SPEED_LIM = 4'(SPEED_MAX);

  // Index 0 = mode key, index 1 = speed key.
  logic [1:0]    w_keys;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_stable;
  logic [CW-1:0] r_cnt [2];
  logic [1:0]    w_accept;
  logic [1:0]    w_press;

  logic [3:0]    r_mode;
  logic [3:0]    r_speed;
  logic          r_mode_pulse;
  logic          r_speed_pulse;

  assign w_keys = {key_speed_n, key_mode_n};

  // The level is accepted on the edge where it has already differed for
  // DEBOUNCE_CYCLES consecutive samples, i.e. the counter sits at its last
  // value and the level still differs.
  always_comb begin
    w_accept = '0;
    w_press  = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      w_accept[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_LAST);
      w_press[i]  = w_accept[i] && r_stable[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_stable <= '1;
      for (int unsigned i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_keys;
      r_sync2 <= r_sync1;
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode        <= 4'd1;
      r_speed       <= '0;
      r_mode_pulse  <= 1'b0;
      r_speed_pulse <= 1'b0;
    end else begin
      r_mode_pulse  <= w_press[0];
      r_speed_pulse <= w_press[1];
      if (w_press[0] && w_press[1]) begin
        r_mode  <= 4'd1;
        r_speed <= '0;
      end else if (w_press[0]) begin
        r_mode <= (r_mode == MODE_LIM) ? 4'd1 : r_mode + 4'd1;
      end else if (w_press[1]) begin
        r_speed <= (r_speed == SPEED_LIM) ? 4'd0 : r_speed + 4'd1;
      end
    end
  end

  assign value       = {r_speed, r_mode};
  assign mode_pulse  = r_mode_pulse;
  assign speed_pulse = r_speed_pulse;

endmodule

// File: tb/tb_key_mode_select.sv
// tb_key_mode_select
//   Directed bench for key_mode_select with DEBOUNCE_CYCLES = 4. Inputs are
//   driven and outputs sampled on the falling clock edge; a monitor counts
//   pulses and remembers the rising-edge index on which each last fired.
module tb_key_mode_select;

  logic       clk;
  logic       rst_n;
  logic       key_mode_n;
  logic       key_speed_n;
  logic [7:0] value;
  logic       mode_pulse;
  logic       speed_pulse;

  int total = 0;
  int bad   = 0;

  int cyc         = 0;
  int mp_cnt      = 0;
  int sp_cnt      = 0;
  int last_mp_cyc = -1;
  int last_sp_cyc = -1;

  key_mode_select #(
    .DEBOUNCE_CYCLES(4),
    .MODE_MAX       (3),
    .SPEED_MAX      (9)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_mode_n (key_mode_n),
    .key_speed_n(key_speed_n),
    .value      (value),
    .mode_pulse (mode_pulse),
    .speed_pulse(speed_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mode_pulse) begin
      mp_cnt++;
      last_mp_cyc = cyc;
    end
    if (speed_pulse) begin
      sp_cnt++;
      last_sp_cyc = cyc;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    key_mode_n  = 1'b1;
    key_speed_n = 1'b1;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(2);
  endtask

  // which: 0 = mode, 1 = speed. Low long enough to be accepted, then released.
  task automatic press_key(input int which);
    if (which == 0) key_mode_n = 1'b0; else key_speed_n = 1'b0;
    wait_cyc(10);
    if (which == 0) key_mode_n = 1'b1; else key_speed_n = 1'b1;
    wait_cyc(10);
  endtask

  int mb, sb, c0;
  logic [7:0] exp_v;

  initial begin
    rst_n       = 1'b0;
    key_mode_n  = 1'b0;
    key_speed_n = 1'b0;

    // Reset with both keys low.
    wait_cyc(3);
    check("rst_value", value, 8'h01);
    check("rst_mpulse", mode_pulse, 0);
    check("rst_spulse", speed_pulse, 0);
    mb = mp_cnt; sb = sp_cnt;
    rst_n       = 1'b1;
    key_speed_n = 1'b1;
    c0 = cyc;
    wait_cyc(12);
    check("rst_hold_mcount", mp_cnt - mb, 1);
    check("rst_hold_scount", sp_cnt - sb, 0);
    check("rst_hold_latency", last_mp_cyc - c0, 6);
    check("rst_hold_value", value, 8'h02);
    key_mode_n = 1'b1;
    wait_cyc(10);

    // Mode wrap.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mb = mp_cnt; sb = sp_cnt;
      press_key(0);
      case (i)
        0: exp_v = 8'h02;
        1: exp_v = 8'h03;
        2: exp_v = 8'h01;
        default: exp_v = 8'h02;
      endcase
      check($sformatf("mode_wrap_value%0d", i), value, exp_v);
      check($sformatf("mode_wrap_mcount%0d", i), mp_cnt - mb, 1);
      check($sformatf("mode_wrap_scount%0d", i), sp_cnt - sb, 0);
    end

    // Speed wrap.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      sb = sp_cnt;
      press_key(1);
      exp_v = {4'((i + 1) % 10), 4'h1};
      check($sformatf("speed_wrap_value%0d", i), value, exp_v);
      check($sformatf("speed_wrap_scount%0d", i), sp_cnt - sb, 1);
    end

    // Bounce on speed, then a clean fall held low.
    mb = mp_cnt; sb = sp_cnt;
    for (int i = 0; i < 5; i++) begin
      key_speed_n = 1'b0;
      wait_cyc(2);
      key_speed_n = 1'b1;
      wait_cyc(2);
    end
    key_speed_n = 1'b0;
    c0 = cyc;
    wait_cyc(12);
    check("bounce_scount", sp_cnt - sb, 1);
    check("bounce_latency", last_sp_cyc - c0, 6);
    check("bounce_value", value, 8'h11);
    key_speed_n = 1'b1;
    wait_cyc(10);

    // 3-cycle glitch on mode is ignored.
    mb = mp_cnt;
    key_mode_n = 1'b0;
    wait_cyc(3);
    key_mode_n = 1'b1;
    wait_cyc(10);
    check("glitch_mcount", mp_cnt - mb, 0);
    check("glitch_value", value, 8'h11);

    // Simultaneous presses load defaults.
    do_reset();
    press_key(0);
    press_key(0);
    for (int i = 0; i < 5; i++) press_key(1);
    check("pre_sim_value", value, 8'h53);
    mb = mp_cnt; sb = sp_cnt;
    key_mode_n  = 1'b0;
    key_speed_n = 1'b0;
    wait_cyc(12);
    check("sim_mcount", mp_cnt - mb, 1);
    check("sim_scount", sp_cnt - sb, 1);
    check("sim_same_edge", last_mp_cyc, last_sp_cyc);
    check("sim_value", value, 8'h01);

    // Mode press while speed is merely held.
    key_mode_n = 1'b1;
    wait_cyc(10);
    mb = mp_cnt; sb = sp_cnt;
    press_key(0);
    check("held_speed_value", value, 8'h02);
    check("held_speed_mcount", mp_cnt - mb, 1);
    check("held_speed_scount", sp_cnt - sb, 0);

    // Long hold: one event only, no repeat, nothing on release.
    mb = mp_cnt;
    key_mode_n = 1'b0;
    wait_cyc(100);
    check("hold_mcount", mp_cnt - mb, 1);
    check("hold_value", value, 8'h03);
    mb = mp_cnt; sb = sp_cnt;
    key_mode_n  = 1'b1;
    key_speed_n = 1'b1;
    wait_cyc(20);
    check("release_mcount", mp_cnt - mb, 0);
    check("release_scount", sp_cnt - sb, 0);
    check("release_value", value, 8'h03);
    mb = mp_cnt;
    press_key(0);
    check("repress_mcount", mp_cnt - mb, 1);
    check("repress_value", value, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
